// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline blocks.
//   - default datapath / register-index widths
//   - $zero register index
//   - MEM/WB control field layout
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // MEM/WB control field bit positions
  localparam int REGWRITE_BIT = 1;
  localparam int MEMTOREG_BIT = 0;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } memwb_ctrl_t;

endpackage

// File: rtl/reg_read_port.sv
// One read port of the GPR file with write-through bypass.
//   idx          : register index to read
//   wr_en/wr_addr/wr_data : write-back bus of the current cycle
//   regs         : full register array
//   rdata        : combinational read result
// $zero always reads 0, even when a write to index 0 is on the bus.
module reg_read_port
  import mips_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic [ADDR_W-1:0]                     idx,
  input  logic                                  wr_en,
  input  logic [ADDR_W-1:0]                     wr_addr,
  input  logic [DATA_W-1:0]                     wr_data,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]    regs,
  output logic [DATA_W-1:0]                     rdata
);

  logic is_zero;
  logic bypass_hit;

  assign is_zero    = (idx == ADDR_W'(REG_ZERO));
  assign bypass_hit = BYPASS_EN && wr_en && (wr_addr == idx);

  always_comb begin
    rdata = regs[idx];
    if (is_zero)         rdata = '0;
    else if (bypass_hit) rdata = wr_data;
  end

endmodule

// File: rtl/reg_file_wb.sv
// Architectural register file (2**ADDR_W x DATA_W) for the 5-stage pipeline.
// Written by WB, read by ID, operands registered into the ID/EX boundary.
//   clk, rst_n     : clock, synchronous active-low reset
//   wb_regWrite, wb_write_reg, wb_data : write-back bus
//   id_rs, id_rt   : source indices from IF/ID
//   id_stall       : hold ex_* operands
//   id_flush       : zero ex_* operands (bubble), beats id_stall
//   id_rs_data, id_rt_data : combinational (bypassed) reads for ID branch compare
//   ex_rs_data, ex_rt_data : registered operands to EX
module reg_file_wb
  import mips_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_regWrite,
  input  logic [ADDR_W-1:0] wb_write_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_stall,
  input  logic              id_flush,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] id_rs_data,
  output logic [DATA_W-1:0] id_rt_data
);

  localparam int NUM_REGS  = 2**ADDR_W;
  localparam int NUM_PORTS = 2;  // [0]=rs, [1]=rt

  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_q;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] rd_idx;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rd_data;
  logic [NUM_PORTS-1:0][DATA_W-1:0] ex_q;
  logic                             wr_fire;

  assign wr_fire = wb_regWrite && (wb_write_reg != ADDR_W'(REG_ZERO));

  // Entry 0 is never written, so it stays at its reset value of 0.
  always_ff @(posedge clk) begin
    if (!rst_n)       regs_q               <= '0;
    else if (wr_fire) regs_q[wb_write_reg] <= wb_data;
  end

  assign rd_idx = {id_rt, id_rs};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
    reg_read_port #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .BYPASS_EN (BYPASS_EN)
    ) u_port (
      .idx     (rd_idx[p]),
      .wr_en   (wb_regWrite),
      .wr_addr (wb_write_reg),
      .wr_data (wb_data),
      .regs    (regs_q),
      .rdata   (rd_data[p])
    );
  end

  // ID/EX operand register. A held operand is not refreshed by a write
  // landing during the stall; EX forwarding covers that case.
  always_ff @(posedge clk) begin
    if (!rst_n)         ex_q <= '0;
    else if (id_flush)  ex_q <= '0;
    else if (!id_stall) ex_q <= rd_data;
  end

  assign id_rs_data = rd_data[0];
  assign id_rt_data = rd_data[1];
  assign ex_rs_data = ex_q[0];
  assign ex_rt_data = ex_q[1];

endmodule

// File: tb/tb_reg_file_wb.sv
module tb_reg_file_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_regWrite;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_data;
  logic [4:0]  id_rs, id_rt;
  logic        id_stall, id_flush;
  logic [31:0] ex_rs_data, ex_rt_data, id_rs_data, id_rt_data;
  logic [31:0] nb_ex_rs, nb_ex_rt, nb_id_rs, nb_id_rt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_regWrite(wb_regWrite), .wb_write_reg(wb_write_reg), .wb_data(wb_data),
    .id_rs(id_rs), .id_rt(id_rt), .id_stall(id_stall), .id_flush(id_flush),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data)
  );

  reg_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS_EN(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .wb_regWrite(wb_regWrite), .wb_write_reg(wb_write_reg), .wb_data(wb_data),
    .id_rs(id_rs), .id_rt(id_rt), .id_stall(id_stall), .id_flush(id_flush),
    .ex_rs_data(nb_ex_rs), .ex_rt_data(nb_ex_rt),
    .id_rs_data(nb_id_rs), .id_rt_data(nb_id_rt)
  );

  // advance one rising edge, then settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_regWrite = 1'b1; wb_write_reg = a; wb_data = d;
    tick();
    wb_regWrite = 1'b0;
  endtask

  task automatic test_reset();
    wb_write(5'd1, 32'h0000_1234);
    wb_write(5'd2, 32'h0000_5678);
    id_rs = 5'd1; id_rt = 5'd2;
    tick();  // load ex_* with nonzero values
    // reset with a write presented in the same cycle
    rst_n = 1'b0;
    wb_regWrite = 1'b1; wb_write_reg = 5'd4; wb_data = 32'h0000_0099;
    tick();
    rst_n = 1'b1; wb_regWrite = 1'b0;
    #1;
    checks++; if (id_rs_data !== 32'h0) begin errors++; $display("FAIL reset_rs1 got=%h exp=%h", id_rs_data, 32'h0); end
    checks++; if (id_rt_data !== 32'h0) begin errors++; $display("FAIL reset_rt2 got=%h exp=%h", id_rt_data, 32'h0); end
    checks++; if (ex_rs_data !== 32'h0) begin errors++; $display("FAIL reset_ex_rs got=%h exp=%h", ex_rs_data, 32'h0); end
    checks++; if (ex_rt_data !== 32'h0) begin errors++; $display("FAIL reset_ex_rt got=%h exp=%h", ex_rt_data, 32'h0); end
    id_rs = 5'd4; #1;
    checks++; if (id_rs_data !== 32'h0) begin errors++; $display("FAIL reset_write_discard got=%h exp=%h", id_rs_data, 32'h0); end
  endtask

  task automatic test_write_read();
    id_rs = 5'd0;
    wb_write(5'd5, 32'hDEAD_BEEF);
    id_rs = 5'd5; #1;
    checks++; if (id_rs_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_rd_id got=%h exp=%h", id_rs_data, 32'hDEAD_BEEF); end
    tick();
    checks++; if (ex_rs_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_rd_ex got=%h exp=%h", ex_rs_data, 32'hDEAD_BEEF); end
  endtask

  task automatic test_zero();
    id_rs = 5'd0; id_rt = 5'd0;
    wb_regWrite = 1'b1; wb_write_reg = 5'd0; wb_data = 32'hFFFF_FFFF;
    #1;
    checks++; if (id_rs_data !== 32'h0) begin errors++; $display("FAIL zero_same_cycle got=%h exp=%h", id_rs_data, 32'h0); end
    tick();
    wb_regWrite = 1'b0; #1;
    checks++; if (id_rt_data !== 32'h0) begin errors++; $display("FAIL zero_after got=%h exp=%h", id_rt_data, 32'h0); end
    checks++; if (ex_rs_data !== 32'h0) begin errors++; $display("FAIL zero_ex got=%h exp=%h", ex_rs_data, 32'h0); end
  endtask

  task automatic test_bypass();
    wb_write(5'd9, 32'h0000_0011);
    id_rt = 5'd9; id_rs = 5'd0;
    wb_regWrite = 1'b1; wb_write_reg = 5'd9; wb_data = 32'h0000_0022;
    #1;
    checks++; if (id_rt_data !== 32'h22) begin errors++; $display("FAIL bypass_id got=%h exp=%h", id_rt_data, 32'h22); end
    checks++; if (nb_id_rt !== 32'h11) begin errors++; $display("FAIL nobypass_id got=%h exp=%h", nb_id_rt, 32'h11); end
    tick();
    wb_regWrite = 1'b0; #1;
    checks++; if (ex_rt_data !== 32'h22) begin errors++; $display("FAIL bypass_ex got=%h exp=%h", ex_rt_data, 32'h22); end
    checks++; if (nb_ex_rt !== 32'h11) begin errors++; $display("FAIL nobypass_ex got=%h exp=%h", nb_ex_rt, 32'h11); end
    // rs == rt
    id_rs = 5'd9; #1;
    checks++; if (id_rs_data !== 32'h22 || id_rt_data !== 32'h22) begin errors++; $display("FAIL same_idx got=%h/%h exp=%h", id_rs_data, id_rt_data, 32'h22); end
  endtask

  task automatic test_stall_flush();
    wb_write(5'd10, 32'hA);
    wb_write(5'd11, 32'hB);
    id_rs = 5'd10; id_rt = 5'd11;
    tick();
    checks++; if (ex_rs_data !== 32'hA) begin errors++; $display("FAIL sf_load got=%h exp=%h", ex_rs_data, 32'hA); end
    id_rs = 5'd11; id_stall = 1'b1;
    tick();
    checks++; if (id_rs_data !== 32'hB) begin errors++; $display("FAIL sf_stall_id got=%h exp=%h", id_rs_data, 32'hB); end
    checks++; if (ex_rs_data !== 32'hA) begin errors++; $display("FAIL sf_stall_hold got=%h exp=%h", ex_rs_data, 32'hA); end
    // write during stall: array updates, held operand does not
    id_rs = 5'd10;
    wb_write(5'd10, 32'hC);
    checks++; if (ex_rs_data !== 32'hA) begin errors++; $display("FAIL sf_stall_write_hold got=%h exp=%h", ex_rs_data, 32'hA); end
    id_flush = 1'b1;
    tick();
    checks++; if (ex_rs_data !== 32'h0 || ex_rt_data !== 32'h0) begin errors++; $display("FAIL sf_flush_over_stall got=%h/%h exp=0", ex_rs_data, ex_rt_data); end
    id_flush = 1'b0; id_stall = 1'b0;
    tick();
    checks++; if (ex_rs_data !== 32'hC) begin errors++; $display("FAIL sf_stall_write_array got=%h exp=%h", ex_rs_data, 32'hC); end
    // write + flush same cycle
    id_flush = 1'b1;
    wb_write(5'd12, 32'h77);
    id_flush = 1'b0;
    checks++; if (ex_rs_data !== 32'h0) begin errors++; $display("FAIL sf_flush_write_ex got=%h exp=%h", ex_rs_data, 32'h0); end
    id_rs = 5'd12; #1;
    checks++; if (id_rs_data !== 32'h77) begin errors++; $display("FAIL sf_flush_write_array got=%h exp=%h", id_rs_data, 32'h77); end
    tick();
    // reset mid-stall
    id_stall = 1'b1; rst_n = 1'b0;
    tick();
    rst_n = 1'b1; id_stall = 1'b0;
    checks++; if (ex_rs_data !== 32'h0) begin errors++; $display("FAIL sf_reset_mid_stall got=%h exp=%h", ex_rs_data, 32'h0); end
  endtask

  task automatic test_no_write();
    wb_write(5'd3, 32'h33);
    wb_regWrite = 1'b0; wb_write_reg = 5'd3; wb_data = 32'h55;
    id_rs = 5'd3; #1;
    checks++; if (id_rs_data !== 32'h33) begin errors++; $display("FAIL nowr_no_bypass got=%h exp=%h", id_rs_data, 32'h33); end
    tick();
    checks++; if (id_rs_data !== 32'h33) begin errors++; $display("FAIL nowr_array got=%h exp=%h", id_rs_data, 32'h33); end
    checks++; if (ex_rs_data !== 32'h33) begin errors++; $display("FAIL nowr_ex got=%h exp=%h", ex_rs_data, 32'h33); end
  endtask

  initial begin
    rst_n = 1'b0; wb_regWrite = 1'b0; wb_write_reg = '0; wb_data = '0;
    id_rs = '0; id_rt = '0; id_stall = 1'b0; id_flush = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    test_reset();
    test_write_read();
    test_zero();
    test_bypass();
    test_stall_flush();
    test_no_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
